// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default pointer geometry, pointer type,
// depth derivation and Gray/binary conversion helpers.
package fifo_pkg;

   // Default address width of the FIFO; pointers carry one extra wrap bit.
   localparam int unsigned FIFO_PTR_WIDTH = 3;

   // Depth derivation from an address width.
   function automatic int unsigned depth_of(input int unsigned ptr_width);
      return 32'd1 << ptr_width;
   endfunction

   localparam int unsigned FIFO_DEPTH = depth_of(FIFO_PTR_WIDTH);

   // Pointer type: address bits plus the wrap bit.
   typedef logic [FIFO_PTR_WIDTH:0] ptr_t;

   // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[FIFO_PTR_WIDTH] = g[FIFO_PTR_WIDTH];
      for (int i = int'(FIFO_PTR_WIDTH) - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Binary to Gray: adjacent binary bits XORed.
   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/w_rptr_sync_level_if.sv
// Bus between the write-pointer side and the read-pointer receiver:
// Gray read pointer in, binary write pointer in, clear pulses, and the
// synchronized pointers / occupancy flags out.
interface w_rptr_sync_level_if #(
   parameter int PTR_WIDTH = 3
);
   logic [PTR_WIDTH:0] G_RPTR;
   logic [PTR_WIDTH:0] B_WPTR;
   logic               HWM_CLR;
   logic               ERR_CLR;
   logic [PTR_WIDTH:0] G_RPTR_SYNC;
   logic [PTR_WIDTH:0] B_RPTR_SYNC;
   logic [PTR_WIDTH:0] W_LEVEL;
   logic               ALMOST_FULL;
   logic [PTR_WIDTH:0] HWM;
   logic               PTR_ERR;

   // Write-side logic: drives pointers and clears, consumes status.
   modport master (
      output G_RPTR, B_WPTR, HWM_CLR, ERR_CLR,
      input  G_RPTR_SYNC, B_RPTR_SYNC, W_LEVEL, ALMOST_FULL, HWM, PTR_ERR
   );

   // Receiver block.
   modport slave (
      input  G_RPTR, B_WPTR, HWM_CLR, ERR_CLR,
      output G_RPTR_SYNC, B_RPTR_SYNC, W_LEVEL, ALMOST_FULL, HWM, PTR_ERR
   );
endinterface

// File: rtl/w_sync_stage.sv
// N-stage flop synchronizer of configurable width. No logic between stages;
// synchronous active-low reset clears every stage.
module w_sync_stage #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             W_CLK,
   input  logic             WRST_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] chain_q [STAGES];

   // Shift the asynchronous sample down the flop chain each W_CLK edge.
   always_ff @(posedge W_CLK) begin
      if (!WRST_n) begin
         for (int i = 0; i < STAGES; i++) begin
            chain_q[i] <= '0;
         end
      end else begin
         chain_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
      end
   end

   assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/w_rptr_sync_level.sv
// Write-domain receiver of the Gray read pointer: synchronizes it, decodes it
// to binary, and derives occupancy, almost-full, a high-water mark and an
// optional sticky pointer-consistency error.
// Optional feature macro: W_RPTR_CHK_EN (enables PTR_ERR and ERR_CLR).
module w_rptr_sync_level
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH   = 3,
   parameter int SYNC_STAGES = 2,
   parameter int AF_THRESH   = 6
) (
   input  logic                W_CLK,
   input  logic                WRST_n,
   w_rptr_sync_level_if.slave  bus
);

   localparam int unsigned DEPTH = depth_of(PTR_WIDTH);
   localparam int unsigned PW1   = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] DEPTH_P  = PW1'(DEPTH);
   localparam logic [PTR_WIDTH:0] AF_THR_P = PW1'(AF_THRESH);

   logic [PTR_WIDTH:0] g_rptr_sync_s;
   logic [PTR_WIDTH:0] b_rptr_d, b_rptr_q;
   logic [PTR_WIDTH:0] lvl_nxt_s;
   logic [PTR_WIDTH:0] level_q;
   logic               af_d, af_q;
   logic [PTR_WIDTH:0] hwm_d, hwm_q;

   w_sync_stage #(
      .WIDTH  (PTR_WIDTH + 1),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .W_CLK  (W_CLK),
      .WRST_n (WRST_n),
      .d_i    (bus.G_RPTR),
      .q_o    (g_rptr_sync_s)
   );

   // Gray-to-binary decode of the synchronized pointer, bit by bit.
   always_comb begin
      b_rptr_d = '0;
      for (int i = 0; i <= PTR_WIDTH; i++) begin
         b_rptr_d[i] = ^(g_rptr_sync_s >> i);
      end
   end

   // Occupancy from the registered read pointer; modular subtraction handles wrap.
   always_comb begin
      lvl_nxt_s = bus.B_WPTR - b_rptr_q;
      af_d      = (lvl_nxt_s >= AF_THR_P);
   end

   // High-water mark: clear reloads the current level, otherwise track the peak.
   always_comb begin
      hwm_d = hwm_q;
      if (bus.HWM_CLR) begin
         hwm_d = lvl_nxt_s;
      end else if (lvl_nxt_s > hwm_q) begin
         hwm_d = lvl_nxt_s;
      end else begin
         hwm_d = hwm_q;
      end
   end

   // Register decoded pointer, level, threshold flag and high-water mark.
   always_ff @(posedge W_CLK) begin
      if (!WRST_n) begin
         b_rptr_q <= '0;
         level_q  <= '0;
         af_q     <= 1'b0;
         hwm_q    <= '0;
      end else begin
         b_rptr_q <= b_rptr_d;
         level_q  <= lvl_nxt_s;
         af_q     <= af_d;
         hwm_q    <= hwm_d;
      end
   end

`ifdef W_RPTR_CHK_EN
   logic err_d, err_q;

   // Sticky error: a level beyond DEPTH means the read pointer overtook the
   // write pointer or a pointer is corrupt; set wins over clear.
   always_comb begin
      err_d = err_q;
      if (lvl_nxt_s > DEPTH_P) begin
         err_d = 1'b1;
      end else if (bus.ERR_CLR) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // Error flag register.
   always_ff @(posedge W_CLK) begin
      if (!WRST_n) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.PTR_ERR = err_q;
`else
   assign bus.PTR_ERR = 1'b0;
`endif

   assign bus.G_RPTR_SYNC = g_rptr_sync_s;
   assign bus.B_RPTR_SYNC = b_rptr_q;
   assign bus.W_LEVEL     = level_q;
   assign bus.ALMOST_FULL = af_q;
   assign bus.HWM         = hwm_q;

endmodule

// File: doc/w_rptr_sync_level.md
# w_rptr_sync_level

Write-domain receiver for the Gray-coded read pointer of the asynchronous FIFO. It does four things:
- Synchronizes the read-domain Gray pointer into W_CLK.
- Decodes the synchronized pointer back to binary.
- Computes the FIFO occupancy as seen from the write side.
- Drives almost-full, a high-water mark and an optional pointer-consistency error.

It sits between the read-pointer handler (in the read domain) and the write-pointer handler. It supplies that handler's synchronized read pointer, which is used for the full comparison.

## Interface
- PTR_WIDTH, 3: address bits. FIFO depth is DEPTH = 2**PTR_WIDTH. Pointers are PTR_WIDTH+1 bits wide, including the wrap bit.
- SYNC_STAGES, 2: flop stages in the CDC synchronizer. Legal values are 2 or more.
- AF_THRESH, 6: ALMOST_FULL asserts when W_LEVEL >= AF_THRESH. Legal range is 1..DEPTH.
- W_CLK  in  1  write-domain clock; all state updates on rising edge.
- WRST_n  in  1  Reset is synchronous and active-low, clocked by W_CLK.
- G_RPTR  in  PTR_WIDTH+1  Gray read pointer, launched from the read domain. It is asynchronous to W_CLK.
- B_WPTR  in  PTR_WIDTH+1  binary write pointer from the write-pointer handler, in the W_CLK domain.
- HWM_CLR  in  1  single-cycle pulse; clears the high-water mark.
- ERR_CLR  in  1  single-cycle pulse; clears the sticky error.
- G_RPTR_SYNC  out  PTR_WIDTH+1  synchronized Gray read pointer.
- B_RPTR_SYNC  out  PTR_WIDTH+1  binary decode of G_RPTR_SYNC, registered.
- W_LEVEL  out  PTR_WIDTH+1  occupancy, range 0..DEPTH, registered.
- ALMOST_FULL  out  1  registered threshold flag.
- HWM  out  PTR_WIDTH+1  peak W_LEVEL since reset or the last clear.
- PTR_ERR  out  1  sticky pointer-consistency error. It is tied to 0 unless the configuration macro is defined.

## Operation
- Synchronizer: a SYNC_STAGES-deep flop chain on G_RPTR. The last stage is G_RPTR_SYNC. There is no logic between stages.
- Decode: B_RPTR_SYNC[i] = XOR of G_RPTR_SYNC[PTR_WIDTH:i]. The result is registered.
- Level: lvl_nxt = (B_WPTR − B_RPTR_SYNC) mod 2**(PTR_WIDTH+1). W_LEVEL <= lvl_nxt.
  - The level is pessimistic: it may over-report occupancy by the synchronizer lag. It never under-reports.
- ALMOST_FULL <= (lvl_nxt >= AF_THRESH). It is registered in the same edge as W_LEVEL, with no hysteresis.
- HWM:
  - If HWM_CLR is high, HWM <= lvl_nxt.
  - Otherwise, if lvl_nxt > HWM, HWM <= lvl_nxt.
  - Otherwise HWM holds.
- PTR_ERR, when compiled in:
  - It sets when lvl_nxt > DEPTH, meaning the read pointer has passed the write pointer or a pointer is corrupt.
  - ERR_CLR clears it.
  - Set has priority over clear in the same cycle.
- No state machine. The block is a fixed pipeline plus three accumulating registers: HWM, PTR_ERR and the synchronizer chain.

## Timing
- Reset, with WRST_n low at an edge:
  - Every synchronizer stage, G_RPTR_SYNC, B_RPTR_SYNC, W_LEVEL, ALMOST_FULL, HWM and PTR_ERR are set to 0.
  - Inputs are ignored while reset is held.
- Reset mid-operation discards all in-flight pointer samples. After release, the first valid G_RPTR_SYNC appears after SYNC_STAGES edges.
- Latency from G_RPTR, counting edges from the first sampling edge:
  - G_RPTR_SYNC updates at edge SYNC_STAGES.
  - B_RPTR_SYNC updates at edge SYNC_STAGES+1.
  - W_LEVEL, ALMOST_FULL and HWM update at edge SYNC_STAGES+2.
- Latency from B_WPTR: 1 edge to W_LEVEL, ALMOST_FULL and HWM.
- Wrap-around: the subtraction is modulo 2**(PTR_WIDTH+1), so no special case is needed.
  - B_WPTR = 0 and B_RPTR_SYNC = 8 with PTR_WIDTH = 3 gives W_LEVEL = 8 (full).
- Simultaneous events:
  - HWM_CLR together with a new peak: HWM loads lvl_nxt.
  - ERR_CLR together with an error condition: PTR_ERR stays 1.

## Configuration
- W_RPTR_CHK_EN:
  - Defined: the PTR_ERR register and its set/clear logic are present, and ERR_CLR is functional.
  - Undefined: PTR_ERR is driven constant 0, ERR_CLR is ignored, and no checker flops are synthesized.

## Structure
- Shared package fifo_pkg holds:
  - the ptr_t typedef (logic [PTR_WIDTH:0]);
  - a gray2bin function and a bin2gray function;
  - the DEPTH constant derivation.
- One sub-module, w_sync_stage: a parameterized N-stage flop synchronizer of configurable width with synchronous active-low reset. It is instantiated once for G_RPTR.

## Test plan
All scenarios use PTR_WIDTH=3, SYNC_STAGES=2 and AF_THRESH=6.
- Reset: drive G_RPTR=4'b0110 and B_WPTR=5 with WRST_n=0 for 3 edges. Every output must be 0 throughout.
- Latency: after reset, set G_RPTR=0 and B_WPTR=5. W_LEVEL=5 one edge later. Then step G_RPTR to gray(2)=4'b0011: G_RPTR_SYNC=4'b0011 at edge 2, B_RPTR_SYNC=2 at edge 3, W_LEVEL=3 at edge 4.
- Wrap decode: set G_RPTR=4'b1100 (gray of 8) and B_WPTR=0. Require B_RPTR_SYNC=4'b1000, W_LEVEL=8, ALMOST_FULL=1.
- Threshold: with B_RPTR_SYNC=0, step B_WPTR 5→6→5.
  - ALMOST_FULL goes 0→1→0.
  - HWM=6 and holds.
  - Pulse HWM_CLR while the level is 5: HWM=5.
- Error, with W_RPTR_CHK_EN defined: set B_WPTR=2 and G_RPTR=gray(5)=4'b0111.
  - W_LEVEL=13 and PTR_ERR=1.
  - ERR_CLR while the error condition persists: PTR_ERR stays 1.
  - Restore B_WPTR=6 (level 1), then ERR_CLR: PTR_ERR=0.
- Macro off: repeat the error scenario. PTR_ERR must remain 0.
